vector_vector_alu: RTL and testbench

VECTOR_VECTOR_ALU -- requirements
Module: vector_vector_alu

---
 rtl/vector_vector_alu_if.sv | 25 ++
 rtl/vector_vector_alu.sv | 101 ++++++++++
 tb/tb_vector_vector_alu.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_vector_alu_if.sv
// vector_vector_alu_if: vector stream bus between the filter-reduce stage, the ALU and its consumer.
interface vector_vector_alu_if #(
    parameter int N = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CW = 2
);
    logic                           valid_in;
    logic                           eof_in;
    logic [CW-1:0]                  chainId_in;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
    logic                           valid_out;
    logic                           eof_out;
    logic [CW-1:0]                  chainId_out;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_out;

    modport master (
        output valid_in, eof_in, chainId_in, vector_in,
        input  valid_out, eof_out, chainId_out, vector_out
    );

    modport slave (
        input  valid_in, eof_in, chainId_in, vector_in,
        output valid_out, eof_out, chainId_out, vector_out
    );
endinterface

// File: rtl/vector_vector_alu.sv
// vector_vector_alu: two-stage per-chain lane-wise PASS/ADD/MAX/MIN accumulator with byte-serial op config.
// Define VVALU_MINMAX_EN to build the MAX/MIN comparators; otherwise ops 2 and 3 act as PASS.
module vector_vector_alu #(
    parameter int N = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4,
    parameter int PERSONAL_CONFIG_ID = 1,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_OP = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tracing,
    input  logic [7:0]           configId,
    input  logic [7:0]           configData,
    vector_vector_alu_if.slave   bus
);
    localparam int CW = MAX_CHAINS > 1 ? $clog2(MAX_CHAINS) : 1;

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic {CFG_IDLE, CFG_OP} cfg_state_t;

    logic [7:0]             ops [MAX_CHAINS];
    vec_t                   acc [MAX_CHAINS];
    logic [MAX_CHAINS-1:0]  empty;
    logic                   s1_valid, s1_eof, s1_empty;
    logic [CW-1:0]          s1_chain, cfg_chain;
    vec_t                   s1_vec, s1_acc, result;
    cfg_state_t             state, state_n;
    logic [7:0]             op;
    logic                   accum, live, wr, fwd, cfg_hit;

    assign op      = ops[s1_chain];
    assign live    = s1_valid & tracing;
    assign wr      = live & accum;
    assign fwd     = wr & (s1_chain == bus.chainId_in);
    assign cfg_hit = !tracing && configId == 8'(PERSONAL_CONFIG_ID);

`ifdef VVALU_MINMAX_EN
    always_comb begin
        accum  = op inside {8'd1, 8'd2, 8'd3};
        result = s1_vec;
        // MAX keeps acc when acc > vec, MIN keeps acc when acc <= vec
        for (int i = 0; i < N; i++)
            result[i] = s1_empty ? s1_vec[i] :
                        op == 8'd1 ? s1_acc[i] + s1_vec[i] :
                        (op == 8'd2) == ($signed(s1_acc[i]) > $signed(s1_vec[i])) ? s1_acc[i] : s1_vec[i];
    end
`else
    always_comb begin
        accum  = op == 8'd1;
        result = s1_vec;
        for (int i = 0; i < N; i++)
            result[i] = s1_empty ? s1_vec[i] : s1_acc[i] + s1_vec[i];
    end
`endif

    always_comb state_n = cfg_hit ? (state == CFG_IDLE ? CFG_OP : CFG_IDLE) : state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= CFG_IDLE;
            cfg_chain       <= '0;
            s1_valid        <= 1'b0;
            empty           <= '1;
            bus.valid_out   <= 1'b0;
            bus.eof_out     <= 1'b0;
            bus.chainId_out <= '0;
            bus.vector_out  <= '0;
            for (int c = 0; c < MAX_CHAINS; c++)
                ops[c] <= INITIAL_FIRMWARE_OP[c*8 +: 8];
        end else begin
            state         <= state_n;
            s1_valid      <= bus.valid_in & tracing;
            bus.valid_out <= live & (!accum | s1_eof);
            if (cfg_hit && state == CFG_IDLE)
                cfg_chain <= configData[CW-1:0];
            if (cfg_hit && state == CFG_OP) begin
                ops[cfg_chain]   <= configData;
                empty[cfg_chain] <= 1'b1;
            end
            if (wr)
                empty[s1_chain] <= s1_eof;
            if (live) begin
                bus.eof_out     <= s1_eof;
                bus.chainId_out <= s1_chain;
                bus.vector_out  <= accum ? result : s1_vec;
            end
        end
    end

    // S2 result is forwarded into S1 when the next vector reads the chain being written
    always_ff @(posedge clk) begin
        s1_eof   <= bus.eof_in;
        s1_chain <= bus.chainId_in;
        s1_vec   <= bus.vector_in;
        s1_acc   <= fwd ? result : acc[bus.chainId_in];
        s1_empty <= fwd ? s1_eof : empty[bus.chainId_in];
        if (wr)
            acc[s1_chain] <= result;
    end
endmodule

// File: tb/tb_vector_vector_alu.sv
// tb_vector_vector_alu: directed spec scenarios plus random traffic checked against a sequential frame model.
module tb_vector_vector_alu;
    localparam int N = 8, DW = 32, MC = 4, CW = 2;
    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef struct {vec_t v; int ch; bit eof;} out_t;
`ifdef VVALU_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, tracing;
    logic [7:0] configId, configData;

    vector_vector_alu_if #(.N(N), .DATA_WIDTH(DW), .CW(CW)) bus ();

    vector_vector_alu #(
        .N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(1),
        .INITIAL_FIRMWARE_OP(32'h0000_0001)
    ) dut (
        .clk(clk), .reset(reset), .tracing(tracing),
        .configId(configId), .configData(configData), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    bit armed = 1'b0;

    // Reference: frames processed one whole vector at a time, in arrival order
    int          m_op [MC];
    vec_t        m_acc [MC];
    bit          m_empty [MC];
    bit          m_phase = 1'b0;
    int          m_cfg_ch = 0;
    bit          pend = 1'b0, p_eof;
    int          p_ch;
    vec_t        p_vec;
    bit          exp_valid = 1'b0, exp_eof;
    logic [CW-1:0] exp_ch;
    vec_t        exp_vec;
    out_t        outs [$];

    function automatic logic [DW-1:0] lane_op(int op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            1: return a + b;
            2: return $signed(a) > $signed(b) ? a : b;
            3: return $signed(a) < $signed(b) ? a : b;
            default: return b;
        endcase
    endfunction

    function automatic vec_t splat(logic [DW-1:0] x);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = x;
        return v;
    endfunction

    task automatic model_edge();
        int op;
        bit acc_op;
        exp_valid = 1'b0;
        if (reset) begin
            for (int c = 0; c < MC; c++) begin
                m_op[c] = (c == 0) ? 1 : 0;
                m_empty[c] = 1'b1;
            end
            m_phase = 1'b0;
            pend = 1'b0;
            return;
        end
        if (pend && tracing) begin
            op = m_op[p_ch];
            acc_op = op == 1 || (MM && (op == 2 || op == 3));
            if (!acc_op) begin
                exp_valid = 1'b1; exp_eof = p_eof; exp_ch = CW'(p_ch); exp_vec = p_vec;
            end else begin
                if (m_empty[p_ch]) m_acc[p_ch] = p_vec;
                else for (int i = 0; i < N; i++) m_acc[p_ch][i] = lane_op(op, m_acc[p_ch][i], p_vec[i]);
                m_empty[p_ch] = 1'b0;
                if (p_eof) begin
                    exp_valid = 1'b1; exp_eof = 1'b1; exp_ch = CW'(p_ch); exp_vec = m_acc[p_ch];
                    m_empty[p_ch] = 1'b1;
                end
            end
        end
        pend = bus.valid_in && tracing;
        p_ch = int'(bus.chainId_in);
        p_eof = bus.eof_in;
        p_vec = bus.vector_in;
        if (!tracing && configId == 8'd1) begin
            if (!m_phase) begin
                m_cfg_ch = int'(configData) % MC;
                m_phase = 1'b1;
            end else begin
                m_op[m_cfg_ch] = int'(configData);
                m_empty[m_cfg_ch] = 1'b1;
                m_phase = 1'b0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (bus.valid_out !== exp_valid) begin
                errors++;
                $display("FAIL valid_out @%0t: got %b want %b", $time, bus.valid_out, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (bus.vector_out !== exp_vec || bus.chainId_out !== exp_ch || bus.eof_out !== exp_eof) begin
                    errors++;
                    $display("FAIL output @%0t: got vec=%h ch=%0d eof=%b want vec=%h ch=%0d eof=%b",
                             $time, bus.vector_out, bus.chainId_out, bus.eof_out, exp_vec, exp_ch, exp_eof);
                end
            end
            if (bus.valid_out === 1'b1)
                outs.push_back('{bus.vector_out, int'(bus.chainId_out), bus.eof_out});
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(bit v, int ch, bit e, vec_t x);
        bus.valid_in = v; bus.chainId_in = CW'(ch); bus.eof_in = e; bus.vector_in = x;
        step();
    endtask

    task automatic idle(int n);
        repeat (n) drive(1'b0, 0, 1'b0, '0);
    endtask

    task automatic cfg(int ch, int op);
        bus.valid_in = 1'b0;
        tracing = 1'b0; configId = 8'd1;
        configData = 8'(ch); step();
        configData = 8'(op); step();
        configId = 8'd0; tracing = 1'b1;
    endtask

    task automatic check_count(string name, int n);
        checks++;
        if (outs.size() != n) begin
            errors++;
            $display("FAIL %s: got %0d outputs want %0d", name, outs.size(), n);
        end
    endtask

    task automatic check_out(string name, int idx, vec_t v, int ch, bit eof);
        checks++;
        if (idx >= outs.size()) begin
            errors++;
            $display("FAIL %s: output #%0d missing, got %0d outputs", name, idx, outs.size());
        end else if (outs[idx].v !== v || outs[idx].ch != ch || outs[idx].eof != eof) begin
            errors++;
            $display("FAIL %s: got vec=%h ch=%0d eof=%b want vec=%h ch=%0d eof=%b",
                     name, outs[idx].v, outs[idx].ch, outs[idx].eof, v, ch, eof);
        end
    endtask

    task automatic check_bit(string name, logic got, logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    initial begin
        vec_t ramp, rv;
        for (int i = 0; i < N; i++) ramp[i] = DW'(i);
        reset = 1'b1; tracing = 1'b1; configId = 8'd0; configData = 8'd0;
        bus.valid_in = 1'b0; bus.eof_in = 1'b0; bus.chainId_in = '0; bus.vector_in = '0;
        step();
        armed = 1'b1;
        step();
        check_bit("rst_valid", bus.valid_out, 1'b0);
        check_bit("rst_eof", bus.eof_out, 1'b0);
        check_bit("rst_vec_zero", bus.vector_out == '0, 1'b1);
        check_bit("rst_chain_zero", bus.chainId_out == '0, 1'b1);
        reset = 1'b0;

        cfg(0, 0);
        outs.delete();
        drive(1'b1, 0, 1'b0, ramp);
        idle(1);
        check_bit("pass_latency", bus.valid_out, 1'b1);
        idle(2);
        check_count("pass_cnt", 1);
        check_out("pass", 0, ramp, 0, 1'b0);

        cfg(1, 1);
        outs.delete();
        drive(1'b1, 1, 1'b0, splat(32'd5));
        drive(1'b1, 1, 1'b0, splat(32'd7));
        drive(1'b1, 1, 1'b1, splat(32'hFFFF_FFFF));
        idle(3);
        check_count("add_cnt", 1);
        check_out("add", 0, splat(32'd11), 1, 1'b1);

        cfg(2, 2);
        outs.delete();
        drive(1'b1, 2, 1'b0, splat(32'hFFFF_FFFD));
        drive(1'b1, 2, 1'b1, splat(32'd9));
        idle(3);
`ifdef VVALU_MINMAX_EN
        check_count("max_cnt", 1);
        check_out("max", 0, splat(32'd9), 2, 1'b1);
`else
        check_count("max_pass_cnt", 2);
        check_out("max_pass0", 0, splat(32'hFFFF_FFFD), 2, 1'b0);
        check_out("max_pass1", 1, splat(32'd9), 2, 1'b1);
`endif

        cfg(0, 1);
        outs.delete();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 0, k == 3, splat(32'd1));
            drive(1'b1, 1, k == 3, splat(32'd2));
        end
        idle(3);
        check_count("interleave_cnt", 2);
        check_out("interleave_ch0", 0, splat(32'd4), 0, 1'b1);
        check_out("interleave_ch1", 1, splat(32'd8), 1, 1'b1);

        cfg(3, 1);
        outs.delete();
        drive(1'b1, 3, 1'b0, splat(32'd10));
        drive(1'b1, 3, 1'b1, splat(32'd20));
        idle(3);
        check_count("cfg_add_cnt", 1);
        check_out("cfg_add", 0, splat(32'd30), 3, 1'b1);
        configId = 8'd1; configData = 8'd3; idle(1);
        configData = 8'd0; idle(1);
        configId = 8'd0;
        outs.delete();
        drive(1'b1, 3, 1'b0, splat(32'd1));
        drive(1'b1, 3, 1'b1, splat(32'd2));
        idle(3);
        check_count("cfg_tracing_cnt", 1);
        check_out("cfg_tracing", 0, splat(32'd3), 3, 1'b1);

        drive(1'b1, 0, 1'b0, splat(32'd4));
        drive(1'b1, 0, 1'b0, splat(32'd4));
        bus.valid_in = 1'b0; tracing = 1'b0; configId = 8'd1; configData = 8'd2;
        step();
        configId = 8'd0; tracing = 1'b1; reset = 1'b1;
        step(); step();
        reset = 1'b0;
        outs.delete();
        drive(1'b1, 0, 1'b1, splat(32'd6));
        idle(3);
        check_count("reset_cnt", 1);
        check_out("reset_frame", 0, splat(32'd6), 0, 1'b1);

        for (int t = 0; t < 3000; t++) begin
            reset = $urandom_range(0, 299) == 0;
            tracing = $urandom_range(0, 9) != 0;
            configId = $urandom_range(0, 2) == 0 ? 8'd1 : 8'($urandom_range(0, 255));
            configData = $urandom_range(0, 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            for (int i = 0; i < N; i++)
                rv[i] = $urandom_range(0, 1) ? DW'($urandom_range(0, 16)) - DW'(8) : DW'($urandom);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, MC - 1), $urandom_range(0, 3) == 0, rv);
        end
        reset = 1'b0; tracing = 1'b1; configId = 8'd0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
